// File: rtl/zigbee_test_ctrl.sv
// zigbee_test_ctrl: test-mode configuration controller for the ZigBee
// transceiver observation/injection fabric.
//  - Loads a 16-bit select word as 4-bit nibbles, least-significant first,
//    into a shadow register.
//  - A commit copies shadow to active atomically.
//  - The outSel* lines are driven from the active register.
//  - Auto-sweep steps {SEL9,SEL15} through all 16 combinations.
//    Each step is held for SETTLE_CYCLES cycles, then followed by one
//    capture-strobe cycle.
// Optional build macro: ZB_TEST_CTRL_CHECKSUM_EN
//  - Requires a 5th nibble equal to the XOR of the four data nibbles.
//  - A commit with a wrong checksum is rejected.
module zigbee_test_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SETTLE_W      = 3
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic [3:0] inNibble,
    input  logic       inNibbleValid,
    input  logic       inCommit,
    input  logic       inSweepStart,
    input  logic       inSweepAbort,
    output logic       outReady,
    output logic       outApplied,
    output logic       outLoadError,
    output logic [2:0] outSel1,
    output logic [2:0] outSel2,
    output logic       outSel3,
    output logic [1:0] outSel6,
    output logic [1:0] outSel9,
    output logic       outSel11,
    output logic       outSel12,
    output logic [1:0] outSel15,
    output logic       outSel17,
    output logic       outCapture,
    output logic       outSweepBusy,
    output logic       outSweepDone
);

`ifdef ZB_TEST_CTRL_CHECKSUM_EN
    localparam logic [2:0] LAST_NIBBLE = 3'd4;
`else
    localparam logic [2:0] LAST_NIBBLE = 3'd3;
`endif
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]          LAST_IDX    = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } stateType;

    // XOR of the four data nibbles of a configuration word.
    function automatic logic [3:0] nibbleXor(input logic [15:0] word);
        nibbleXor = word[3:0] ^ word[7:4] ^ word[11:8] ^ word[15:12];
    endfunction

    stateType              state;
    stateType              stateNext;
    logic [15:0]           shadow;
    logic [15:0]           shadowNext;
    logic [2:0]            nibCnt;
    logic [2:0]            nibCntNext;
    logic                  shadowFull;
    logic                  shadowFullNext;
    logic [15:0]           active;
    logic [15:0]           activeNext;
    logic [3:0]            sweepIdx;
    logic [3:0]            sweepIdxNext;
    logic [SETTLE_W-1:0]   settleCnt;
    logic [SETTLE_W-1:0]   settleCntNext;
    logic                  appliedNext;
    logic                  loadErrorNext;
    logic                  commitOk;
    logic [1:0]            sel9Next;
    logic [1:0]            sel15Next;
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
    logic [3:0]            checksum;
    logic [3:0]            checksumNext;
`endif

    // Decide whether a commit on the current shadow contents is acceptable.
    always_comb begin
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
        commitOk = shadowFull && (nibbleXor(shadow) == checksum);
`else
        commitOk = shadowFull;
`endif
    end

    // Next-state logic: sweep sequencing, nibble loading, and commit handling.
    always_comb begin
        stateNext      = state;
        shadowNext     = shadow;
        nibCntNext     = nibCnt;
        shadowFullNext = shadowFull;
        activeNext     = active;
        sweepIdxNext   = sweepIdx;
        settleCntNext  = settleCnt;
        appliedNext    = 1'b0;
        loadErrorNext  = 1'b0;
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
        checksumNext   = checksum;
`endif
        case (state)
            IDLE: begin
                if (inSweepStart) begin
                    // Sweep wins over a simultaneous commit or nibble.
                    stateNext     = SETTLE;
                    sweepIdxNext  = 4'd0;
                    settleCntNext = '0;
                end else if (inCommit) begin
                    // Commit sees the pre-cycle shadow; a same-cycle nibble is dropped.
                    nibCntNext     = 3'd0;
                    shadowFullNext = 1'b0;
                    if (commitOk) begin
                        activeNext  = shadow;
                        appliedNext = 1'b1;
                    end else begin
                        loadErrorNext = 1'b1;
                    end
                end else if (inNibbleValid) begin
                    if (shadowFull) begin
                        // A nibble after a complete load starts a fresh load.
                        shadowNext[3:0] = inNibble;
                        nibCntNext      = 3'd1;
                        shadowFullNext  = 1'b0;
                    end else begin
                        case (nibCnt)
                            3'd0:    shadowNext[3:0]   = inNibble;
                            3'd1:    shadowNext[7:4]   = inNibble;
                            3'd2:    shadowNext[11:8]  = inNibble;
                            3'd3:    shadowNext[15:12] = inNibble;
                            default: begin
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
                                checksumNext = inNibble;
`endif
                            end
                        endcase
                        if (nibCnt == LAST_NIBBLE) begin
                            nibCntNext     = 3'd0;
                            shadowFullNext = 1'b1;
                        end else begin
                            nibCntNext = nibCnt + 3'd1;
                        end
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            SETTLE: begin
                loadErrorNext = inCommit;
                if (inSweepAbort) begin
                    stateNext = IDLE;
                end else if (settleCnt == SETTLE_LAST) begin
                    stateNext = CAPTURE;
                end else begin
                    settleCntNext = settleCnt + 1'b1;
                end
            end
            CAPTURE: begin
                loadErrorNext = inCommit;
                if (inSweepAbort) begin
                    stateNext = IDLE;
                end else if (sweepIdx == LAST_IDX) begin
                    stateNext = DONE;
                end else begin
                    sweepIdxNext  = sweepIdx + 4'd1;
                    settleCntNext = '0;
                    stateNext     = SETTLE;
                end
            end
            DONE: begin
                loadErrorNext = inCommit;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Observation selects follow the sweep index while a step is active, else the active word.
    always_comb begin
        sel9Next  = activeNext[10:9];
        sel15Next = activeNext[14:13];
        if ((stateNext == SETTLE) || (stateNext == CAPTURE)) begin
            sel9Next  = sweepIdxNext[3:2];
            sel15Next = sweepIdxNext[1:0];
        end else begin
            sel9Next  = activeNext[10:9];
            sel15Next = activeNext[14:13];
        end
    end

    // FSM state register.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath registers: shadow/active configuration and sweep counters.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            shadow     <= 16'd0;
            nibCnt     <= 3'd0;
            shadowFull <= 1'b0;
            active     <= 16'd0;
            sweepIdx   <= 4'd0;
            settleCnt  <= '0;
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
            checksum   <= 4'd0;
`endif
        end else begin
            shadow     <= shadowNext;
            nibCnt     <= nibCntNext;
            shadowFull <= shadowFullNext;
            active     <= activeNext;
            sweepIdx   <= sweepIdxNext;
            settleCnt  <= settleCntNext;
`ifdef ZB_TEST_CTRL_CHECKSUM_EN
            checksum   <= checksumNext;
`endif
        end
    end

    // Registered outputs, computed from next-state so they line up with the state they describe.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            outReady     <= 1'b1;
            outApplied   <= 1'b0;
            outLoadError <= 1'b0;
            outCapture   <= 1'b0;
            outSweepBusy <= 1'b0;
            outSweepDone <= 1'b0;
            outSel1      <= 3'd0;
            outSel2      <= 3'd0;
            outSel3      <= 1'b0;
            outSel6      <= 2'd0;
            outSel9      <= 2'd0;
            outSel11     <= 1'b0;
            outSel12     <= 1'b0;
            outSel15     <= 2'd0;
            outSel17     <= 1'b0;
        end else begin
            outReady     <= (stateNext == IDLE);
            outApplied   <= appliedNext;
            outLoadError <= loadErrorNext;
            outCapture   <= (stateNext == CAPTURE);
            outSweepBusy <= (stateNext != IDLE);
            outSweepDone <= (stateNext == DONE);
            outSel1      <= activeNext[2:0];
            outSel2      <= activeNext[5:3];
            outSel3      <= activeNext[6];
            outSel6      <= activeNext[8:7];
            outSel9      <= sel9Next;
            outSel11     <= activeNext[11];
            outSel12     <= activeNext[12];
            outSel15     <= sel15Next;
            outSel17     <= activeNext[15];
        end
    end

endmodule

// File: doc/zigbee_test_ctrl.md
Name: zigbee_test_ctrl

Overview:
Test-mode configuration controller for the ZigBee transceiver observation/injection fabric.
- Loads a 16-bit select configuration as 4-bit nibbles over the shared test pins.
- Applies the configuration atomically on commit and drives every DEMUX/MUX select line of the top level.
- Provides an auto-sweep mode that steps the MUX9/MUX15 observation selects through all 16 combinations, issuing a capture strobe per step for the tester.

Parameters:
SETTLE_CYCLES, 4, cycles held per sweep step before the capture strobe (>=1)
SETTLE_W, 3, width of the settle counter; must hold SETTLE_CYCLES

Ports:
inClock  in  1  system clock, all logic on rising edge
inReset  in  1  asynchronous, active-high reset
inNibble  in  4  configuration nibble
inNibbleValid  in  1  nibble strobe, one nibble per cycle
inCommit  in  1  apply shadow configuration
inSweepStart  in  1  start observation sweep
inSweepAbort  in  1  abort sweep
outReady  out  1  controller idle, accepts nibbles/commit/start
outApplied  out  1  1-cycle pulse: config applied
outLoadError  out  1  1-cycle pulse: rejected commit
outSel1  out  3  DEMUX1 select
outSel2  out  3  DEMUX2 select
outSel3  out  1  MUX3/4/5 select
outSel6  out  2  MUX6/7/8 select
outSel9  out  2  MUX9/10 select
outSel11  out  1  MUX11/14 select
outSel12  out  1  MUX12/13 select
outSel15  out  2  MUX15/16 select
outSel17  out  1  DEMUX17/18 select
outCapture  out  1  1-cycle capture strobe during sweep
outSweepBusy  out  1  sweep in progress
outSweepDone  out  1  1-cycle pulse: sweep completed

Behaviour:
- Config word layout: [2:0]SEL1 [5:3]SEL2 [6]SEL3 [8:7]SEL6 [10:9]SEL9 [11]SEL11 [12]SEL12 [14:13]SEL15 [15]SEL17.
- Reset (async, any time, including mid-load or mid-sweep):
  - active and shadow registers = 0; all outSel* = 0.
  - nibble count = 0, shadow_full = 0, state = IDLE.
  - outReady = 1; all pulses, outCapture and outSweepBusy = 0.
- outSel* are registered and come from the active register, except during a sweep (below).
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, load:
  - inNibbleValid writes shadow[4*cnt+:4], cnt = cnt+1. Least-significant nibble first.
  - The 4th nibble sets shadow_full and wraps cnt to 0.
  - Further nibbles while shadow_full restart the load: overwrite from nibble 0 and clear shadow_full.
- IDLE, commit with shadow_full: active <= shadow on that edge, so outSel* change and outApplied pulses in the next cycle. cnt and shadow_full are cleared.
- IDLE, commit without shadow_full: outLoadError pulses next cycle, active is unchanged, cnt is cleared.
- Simultaneous inNibbleValid and inCommit: commit evaluated on the pre-cycle state; the nibble is discarded.
- Simultaneous inSweepStart and commit/nibble: the sweep takes priority and the other inputs are discarded.
- IDLE + inSweepStart, accepted at cycle 0:
  - idx = 0, go to SETTLE; outReady = 0 and outSweepBusy = 1 from cycle 1.
  - During the sweep, outSel9 = idx[3:2] and outSel15 = idx[1:0]; other selects hold their active values.
- SETTLE: lasts SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE: 1 cycle, outCapture = 1.
  - idx < 15: idx++, back to SETTLE.
  - idx = 15: go to DONE.
  - With defaults, captures occur at cycles 5, 10, ..., 80.
- DONE: 1 cycle at cycle 81.
  - outSweepDone = 1; outSel9/outSel15 restored from active.
  - Returns to IDLE; outReady = 1 at cycle 82.
- Abort: inSweepAbort in SETTLE or CAPTURE returns to IDLE next cycle.
  - Selects are restored; no outSweepDone pulse.
  - A capture in the abort cycle still completes.
- While not IDLE: nibbles are ignored; inCommit produces an outLoadError pulse. Shadow is preserved.

Optional Feature:
ZB_TEST_CTRL_CHECKSUM_EN:
- Defined: a 5th nibble (checksum) is required, equal to the XOR of the 4 data nibbles.
  - shadow_full is set only after the 5th nibble.
  - Commit with a checksum mismatch raises outLoadError and leaves active unchanged.
- Undefined: 4 nibbles, no checksum.

Test Plan:
- Load: reset, nibbles 3,C,5,A, commit -> next cycle outApplied=1, SEL1=3, SEL2=0, SEL3=1, SEL6=3, SEL9=2, SEL11=0, SEL12=0, SEL15=1, SEL17=1. With CHECKSUM_EN, a 5th nibble 0 gives the same result; a 5th nibble 1 -> outLoadError, selects stay 0.
- Partial load: 2 nibbles then commit -> outLoadError pulse, selects unchanged; the next full 4-nibble load plus commit applies correctly.
- Sweep: SETTLE_CYCLES=4, start at cycle 0 -> 16 outCapture pulses at cycles 5..80 step 5, with (SEL9,SEL15) = (0,0), (0,1) ... (3,3). outSweepDone at cycle 81, SEL9/SEL15 restored to 2/1, outReady=1 at cycle 82.
- Abort: abort at cycle 23 -> IDLE at cycle 24, no outSweepDone, selects restored, exactly 4 captures seen.
- Busy rejection: commit during sweep -> outLoadError, active unchanged; nibbles during sweep have no effect on the later load count.
- Async reset mid-sweep (cycle 12) -> all outputs 0 and outReady=1 immediately, without waiting for a clock edge.
